// File: rtl/fetch_unit_if.sv
// Port bundle between the fetch stage, its upstream control (hazard/decode),
// the instruction memory and the decode stage.
interface fetch_unit_if;
    logic        stall;
    logic [1:0]  npc_sel;
    logic        branch_taken;
    logic [31:0] rs_D;
    logic [31:0] Instr_F;
    logic [31:0] PC_F;
    logic [31:0] IR_D;
    logic [31:0] PC_D;
    logic [31:0] PC8_D;
    logic        addr_err;
    logic [31:0] fetch_cnt;

    // Control/memory side: drives redirect controls and the fetched word.
    modport master (
        output stall, npc_sel, branch_taken, rs_D, Instr_F,
        input  PC_F, IR_D, PC_D, PC8_D, addr_err, fetch_cnt
    );

    // Fetch stage itself.
    modport slave (
        input  stall, npc_sel, branch_taken, rs_D, Instr_F,
        output PC_F, IR_D, PC_D, PC8_D, addr_err, fetch_cnt
    );
endinterface

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: program counter, IF/ID register and next-PC
// selection resolved from the instruction in D (one-slot branch delay, no flush).
module fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int          IM_WORDS = 1024
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        NPC_SEQ = 2'b00,
        NPC_BR  = 2'b01,
        NPC_JMP = 2'b10,
        NPC_JR  = 2'b11
    } npc_sel_e;

    localparam logic [32:0] PC_LIMIT = {1'b0, PC_RESET} + 33'(4 * IM_WORDS);

    logic [31:0] pc_f;
    logic [31:0] ir_d;
    logic [31:0] pc_d;
    logic [31:0] fetch_cnt;

    npc_sel_e    sel;
    logic [31:0] seq_pc;
    logic [31:0] br_off;
    logic [31:0] br_pc;
    logic [31:0] jmp_pc;
    logic [31:0] npc;

    assign sel    = npc_sel_e'(bus.npc_sel);
    assign seq_pc = pc_f + 32'd4;
    assign br_off = {{14{ir_d[15]}}, ir_d[15:0], 2'b00};
    assign br_pc  = pc_d + 32'd4 + br_off;
    assign jmp_pc = {pc_d[31:28], ir_d[25:0], 2'b00};

    // NOTE: npc gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        npc = seq_pc;
        unique case (sel)
            NPC_SEQ: npc = seq_pc;
            NPC_BR:  npc = bus.branch_taken ? br_pc : seq_pc;
            NPC_JMP: npc = jmp_pc;
            NPC_JR:  npc = bus.rs_D;
            default: npc = seq_pc;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values;
    // the async reset clears state immediately, independent of clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_f      <= PC_RESET;
            ir_d      <= 32'h0;
            pc_d      <= PC_RESET;
            fetch_cnt <= 32'h0;
        end else if (!bus.stall) begin
            pc_f      <= npc;
            ir_d      <= bus.Instr_F;
            pc_d      <= pc_f;
            fetch_cnt <= fetch_cnt + 32'd1;
        end
    end

    // Out-of-window or misaligned fetches are flagged but never blocked.
    assign bus.addr_err = (pc_f[1:0] != 2'b00)
                        | (pc_f < PC_RESET)
                        | ({1'b0, pc_f} >= PC_LIMIT);

    assign bus.PC_F      = pc_f;
    assign bus.IR_D      = ir_d;
    assign bus.PC_D      = pc_d;
    assign bus.PC8_D     = pc_d + 32'd8;
    assign bus.fetch_cnt = fetch_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus pushes hand-computed expectations,
// an independent monitor pops and compares after each edge or reset assertion.
module tb_fetch_unit;

    logic clk;
    logic reset;

    fetch_unit_if ifc ();

    fetch_unit #(
        .PC_RESET (32'h0000_3000),
        .IM_WORDS (1024)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    typedef struct {
        string       name;
        logic [31:0] pc_f;
        logic [31:0] ir_d;
        logic [31:0] pc_d;
        logic [31:0] cnt;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem [0:1023];
    int          n_checks = 0;
    int          n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: combinational read, fixed pattern outside window.
    always_comb begin
        if (ifc.PC_F >= 32'h3000 && ifc.PC_F < 32'h4000)
            ifc.Instr_F = mem[ifc.PC_F[11:2]];
        else
            ifc.Instr_F = 32'hBAD0_BAD0;
    end

    function automatic logic [31:0] imem(input logic [31:0] a);
        if (a >= 32'h3000 && a < 32'h4000) return mem[a[11:2]];
        return 32'hBAD0_BAD0;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
        end
    endtask

    task automatic expect_state(input string nm, input logic [31:0] pcf, input logic [31:0] ir,
                                input logic [31:0] pcd, input logic [31:0] cnt, input logic err);
        exp_t e;
        e.name = nm; e.pc_f = pcf; e.ir_d = ir; e.pc_d = pcd; e.cnt = cnt; e.err = err;
        exp_q.push_back(e);
    endtask

    // Called at a negedge: drive inputs, queue the post-edge expectation, return at next negedge.
    task automatic step(input logic st, input logic [1:0] sel, input logic tk, input logic [31:0] rs,
                        input logic [31:0] pcf, input logic [31:0] ir, input logic [31:0] pcd,
                        input logic [31:0] cnt, input logic err, input string nm);
        ifc.stall        = st;
        ifc.npc_sel      = sel;
        ifc.branch_taken = tk;
        ifc.rs_D         = rs;
        expect_state(nm, pcf, ir, pcd, cnt, err);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: samples just after each clock edge or reset assertion.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or posedge reset);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.name, ".PC_F"},      ifc.PC_F,      e.pc_f);
                check({e.name, ".IR_D"},      ifc.IR_D,      e.ir_d);
                check({e.name, ".PC_D"},      ifc.PC_D,      e.pc_d);
                check({e.name, ".PC8_D"},     ifc.PC8_D,     e.pc_d + 32'd8);
                check({e.name, ".fetch_cnt"}, ifc.fetch_cnt, e.cnt);
                check({e.name, ".addr_err"},  {31'b0, ifc.addr_err}, {31'b0, e.err});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h2400_0000 | 32'(i);
        mem[4] = 32'h1000_FFFC;   // beq at 0x3010, imm16 = -4
        mem[8] = 32'h0C00_0C10;   // jal at 0x3020, target 0x3040

        reset            = 1'b0;
        ifc.stall        = 1'b0;
        ifc.npc_sel      = 2'b00;
        ifc.branch_taken = 1'b0;
        ifc.rs_D         = 32'h0;
        #1;
        expect_state("reset", 32'h3000, 32'h0, 32'h3000, 32'd0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Free-running sequential fetch
        step(0, 2'b00, 0, 0, 32'h3004, imem(32'h3000), 32'h3000, 32'd1, 0, "seq1");
        step(0, 2'b00, 0, 0, 32'h3008, imem(32'h3004), 32'h3004, 32'd2, 0, "seq2");
        step(0, 2'b00, 0, 0, 32'h300C, imem(32'h3008), 32'h3008, 32'd3, 0, "seq3");
        step(0, 2'b00, 0, 0, 32'h3010, imem(32'h300C), 32'h300C, 32'd4, 0, "seq4");
        step(0, 2'b00, 0, 0, 32'h3014, 32'h1000_FFFC,  32'h3010, 32'd5, 0, "beq_in_d");

        // Taken branch back to 0x3004, delay slot 0x3014 captured
        step(0, 2'b01, 1, 0, 32'h3004, imem(32'h3014), 32'h3014, 32'd6, 0, "beq_taken");
        step(0, 2'b00, 0, 0, 32'h3008, imem(32'h3004), 32'h3004, 32'd7, 0, "br_target");
        step(0, 2'b00, 0, 0, 32'h300C, imem(32'h3008), 32'h3008, 32'd8, 0, "seq8");
        step(0, 2'b00, 0, 0, 32'h3010, imem(32'h300C), 32'h300C, 32'd9, 0, "seq9");
        step(0, 2'b00, 0, 0, 32'h3014, 32'h1000_FFFC,  32'h3010, 32'd10, 0, "beq_again");

        // Not-taken branch falls through to PC_F + 4
        step(0, 2'b01, 0, 0, 32'h3018, imem(32'h3014), 32'h3014, 32'd11, 0, "beq_not_taken");
        step(0, 2'b00, 0, 0, 32'h301C, imem(32'h3018), 32'h3018, 32'd12, 0, "seq12");
        step(0, 2'b00, 0, 0, 32'h3020, imem(32'h301C), 32'h301C, 32'd13, 0, "seq13");
        step(0, 2'b00, 0, 0, 32'h3024, 32'h0C00_0C10,  32'h3020, 32'd14, 0, "jal_in_d");

        // jal: target 0x3040
        step(0, 2'b10, 0, 0, 32'h3040, imem(32'h3024), 32'h3024, 32'd15, 0, "jal_redirect");
        step(0, 2'b00, 0, 0, 32'h3044, imem(32'h3040), 32'h3040, 32'd16, 0, "jal_target");

        // jr targets exercising alignment and window edges
        step(0, 2'b11, 0, 32'h0000_3002, 32'h3002, imem(32'h3044), 32'h3044, 32'd17, 1, "jr_misaligned");
        step(0, 2'b11, 0, 32'h0000_4000, 32'h4000, imem(32'h3002), 32'h3002, 32'd18, 1, "jr_above_window");
        step(0, 2'b11, 0, 32'h0000_3FFC, 32'h3FFC, 32'hBAD0_BAD0,  32'h4000, 32'd19, 0, "jr_last_word");
        step(0, 2'b11, 0, 32'h0000_2FFC, 32'h2FFC, imem(32'h3FFC), 32'h3FFC, 32'd20, 1, "jr_below_window");
        step(0, 2'b11, 0, 32'h0000_3000, 32'h3000, 32'hBAD0_BAD0,  32'h2FFC, 32'd21, 0, "jr_back");

        step(0, 2'b00, 0, 0, 32'h3004, imem(32'h3000), 32'h3000, 32'd22, 0, "seq22");
        step(0, 2'b00, 0, 0, 32'h3008, imem(32'h3004), 32'h3004, 32'd23, 0, "seq23");
        step(0, 2'b00, 0, 0, 32'h300C, imem(32'h3008), 32'h3008, 32'd24, 0, "seq24");
        step(0, 2'b00, 0, 0, 32'h3010, imem(32'h300C), 32'h300C, 32'd25, 0, "seq25");
        step(0, 2'b00, 0, 0, 32'h3014, 32'h1000_FFFC,  32'h3010, 32'd26, 0, "beq_stall_setup");

        // Stall overrides a pending taken branch for exactly three edges
        step(1, 2'b01, 1, 0, 32'h3014, 32'h1000_FFFC,  32'h3010, 32'd26, 0, "stall1");
        step(1, 2'b01, 1, 0, 32'h3014, 32'h1000_FFFC,  32'h3010, 32'd26, 0, "stall2");
        step(1, 2'b01, 1, 0, 32'h3014, 32'h1000_FFFC,  32'h3010, 32'd26, 0, "stall3");
        step(0, 2'b01, 1, 0, 32'h3004, imem(32'h3014), 32'h3014, 32'd27, 0, "stall_release");

        step(0, 2'b00, 0, 0, 32'h3008, imem(32'h3004), 32'h3004, 32'd28, 0, "seq28");
        step(0, 2'b00, 0, 0, 32'h300C, imem(32'h3008), 32'h3008, 32'd29, 0, "seq29");
        step(0, 2'b00, 0, 0, 32'h3010, imem(32'h300C), 32'h300C, 32'd30, 0, "seq30");
        step(0, 2'b00, 0, 0, 32'h3014, 32'h1000_FFFC,  32'h3010, 32'd31, 0, "seq31");
        step(0, 2'b00, 0, 0, 32'h3018, imem(32'h3014), 32'h3014, 32'd32, 0, "seq32");
        step(0, 2'b00, 0, 0, 32'h301C, imem(32'h3018), 32'h3018, 32'd33, 0, "seq33");
        step(0, 2'b00, 0, 0, 32'h3020, imem(32'h301C), 32'h301C, 32'd34, 0, "seq34");
        step(0, 2'b00, 0, 0, 32'h3024, 32'h0C00_0C10,  32'h3020, 32'd35, 0, "jal_stall_setup");
        step(1, 2'b10, 0, 0, 32'h3024, 32'h0C00_0C10,  32'h3020, 32'd35, 0, "jal_stalled");

        // Asynchronous reset mid-cycle, while the jump is stalled in D
        #2;
        expect_state("async_reset", 32'h3000, 32'h0, 32'h3000, 32'd0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        ifc.stall   = 1'b0;
        ifc.npc_sel = 2'b00;
        reset       = 1'b0;
        step(0, 2'b00, 0, 0, 32'h3004, imem(32'h3000), 32'h3000, 32'd1, 0, "post_reset");

        #1;
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
